// File: rtl/audio_fifo_reader_if.sv
// rtl/audio_fifo_reader_if.sv - FIFO read port and PCM sample output bundle
//
// Signals:
//   fifo_empty    FIFO empty flag                       (FIFO -> reader)
//   fifo_q        FIFO read data, valid after rdreq     (FIFO -> reader)
//   fifo_rdreq    single-cycle read request             (reader -> FIFO)
//   sample_out    current 16-bit PCM sample             (reader -> codec)
//   sample_valid  one-cycle pulse on sample update      (reader -> codec)
//
// master: the reader side. slave: the FIFO/codec side (or a bench).

interface audio_fifo_reader_if;
    logic        fifo_empty;
    logic [31:0] fifo_q;
    logic        fifo_rdreq;
    logic [15:0] sample_out;
    logic        sample_valid;

    modport master (
        input  fifo_empty,
        input  fifo_q,
        output fifo_rdreq,
        output sample_out,
        output sample_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_q,
        input  fifo_rdreq,
        input  sample_out,
        input  sample_valid
    );
endinterface

// File: rtl/audio_fifo_reader.sv
// rtl/audio_fifo_reader.sv - pops 32-bit FIFO words and plays them as paced 16-bit PCM samples
//
// Ports:
//   i_clk              system clock (FIFO read port shares it)
//   i_reset            synchronous, active-high reset
//   i_div_freq         clocks per output sample; period = max(i_div_freq, MIN_PERIOD)
//   i_pause            level; freezes counter, FSM and outputs
//   i_stop             level; flushes the reader to idle (wins over i_pause)
//   bus                FIFO read port + sample output (master view)
//   o_underflow_count  ticks that found no sample ready; saturates at 0xFFFF

module audio_fifo_reader #(
    parameter int unsigned MIN_PERIOD = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [31:0]         i_div_freq,
    input  logic                i_pause,
    input  logic                i_stop,
    audio_fifo_reader_if.master bus,
    output logic [15:0]         o_underflow_count
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        LATCH   = 2'd1,
        EMIT_LO = 2'd2,
        EMIT_HI = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_cnt;
    logic [31:0] r_word;
    logic [15:0] r_sample_out;
    logic        r_sample_valid;
    logic [15:0] r_underflow_count;

    logic [31:0] w_period;
    logic [31:0] w_period_m1;
    logic        w_running;
    logic        w_tick;
    logic        w_underflow;
    logic        w_rdreq;

    // The floor guarantees the FETCH -> LATCH -> EMIT_LO refill (3 cycles)
    // always completes before the next tick after an EMIT_HI tick.
    assign w_period    = (i_div_freq < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : i_div_freq;
    assign w_period_m1 = w_period - 32'd1;

    assign w_running = !i_stop && !i_pause;

    // >= rather than == so that shrinking the period mid-count fires at once
    // instead of wrapping the counter.
    assign w_tick = w_running && (r_cnt >= w_period_m1);

    // A tick while no word is ready to emit is a lost sample.
    assign w_underflow = w_tick && ((r_state == FETCH) || (r_state == LATCH));

    // ------------------------------------------------------------------
    // Rate counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset || i_stop) begin
            r_cnt <= 32'd0;
        end else if (w_tick) begin
            r_cnt <= 32'd0;
        end else if (w_running) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (i_stop) begin
            w_next_state = FETCH;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_running && !bus.fifo_empty) begin
                        w_next_state = LATCH;
                    end
                end
                // The read has already been issued, so the word is taken
                // and the FSM moves on even if pause rises this cycle; no
                // tick can happen while paused, so nothing is emitted early.
                LATCH: begin
                    w_next_state = EMIT_LO;
                end
                EMIT_LO: begin
                    if (w_tick) begin
                        w_next_state = EMIT_HI;
                    end
                end
                EMIT_HI: begin
                    if (w_tick) begin
                        w_next_state = FETCH;
                    end
                end
                default: begin
                    w_next_state = FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_rdreq = 1'b0;
        // Only FETCH issues reads and FETCH always leaves for LATCH when it
        // does, so at most one read is ever outstanding.
        if (!i_reset && (r_state == FETCH) && w_running && !bus.fifo_empty) begin
            w_rdreq = 1'b1;
        end
    end

    assign bus.fifo_rdreq = w_rdreq;

    // ------------------------------------------------------------------
    // Word register: normal-mode FIFO presents data the cycle after rdreq
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_word <= 32'd0;
        end else if ((r_state == LATCH) && !i_stop) begin
            r_word <= bus.fifo_q;
        end
    end

    // ------------------------------------------------------------------
    // Sample output: low half first, then high half
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset || i_stop) begin
            r_sample_out   <= 16'd0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (w_tick && (r_state == EMIT_LO)) begin
                r_sample_out   <= r_word[15:0];
                r_sample_valid <= 1'b1;
            end else if (w_tick && (r_state == EMIT_HI)) begin
                r_sample_out   <= r_word[31:16];
                r_sample_valid <= 1'b1;
            end
        end
    end

    assign bus.sample_out   = r_sample_out;
    assign bus.sample_valid = r_sample_valid;

    // ------------------------------------------------------------------
    // Underflow counter: survives stop, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_underflow_count <= 16'd0;
        end else if (w_underflow && (r_underflow_count != 16'hFFFF)) begin
            r_underflow_count <= r_underflow_count + 16'd1;
        end
    end

    assign o_underflow_count = r_underflow_count;

endmodule

// File: doc/audio_fifo_reader.md
# audio_fifo_reader

Playback-side consumer of the audio sample FIFO that the Nios II software fills through the `audio2fifo` PIO bank. It pops 32-bit words from a normal-mode (non-show-ahead) single-clock FIFO, unpacks each word into two 16-bit PCM samples (low half first), and emits one sample per rate tick derived from `div_freq`. It honors the software `pause`/`stop` controls and counts underflows. It sits between the FIFO read port and the audio DAC/codec serializer.

## Interface
- `MIN_PERIOD`, 4: floor on the sample period in clocks; guarantees that a FIFO fetch completes between ticks.
- `clk`  in  1  system clock; the FIFO read port runs on this same clock.
- `reset`  in  1  synchronous, active-high reset.
- `div_freq`  in  32  clocks per output sample; effective period P = max(div_freq, MIN_PERIOD).
- `pause`  in  1  level; freezes the rate counter, the FSM and the outputs.
- `stop`  in  1  level; flushes the reader to its idle state. Has priority over `pause`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_q`  in  32  FIFO read data; valid the cycle after `fifo_rdreq`.
- `fifo_rdreq`  out  1  single-cycle read request.
- `sample_out`  out  16  current PCM sample, held between updates.
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates.
- `underflow_count`  out  16  number of ticks with no sample available; saturates at 0xFFFF.

## Operation
- Priority: `reset` > `stop` > `pause` > normal operation.
- Rate counter `cnt` (32 bit). Define running = !stop && !pause.
  - tick = running && (cnt >= P-1).
  - On tick, `cnt` becomes 0. Otherwise, while running, `cnt` increments.
  - While paused, `cnt` holds. `stop` clears `cnt` to 0.
  - The >= compare means that lowering `div_freq` mid-count fires a tick immediately; it never wraps.
- FSM states: FETCH, LATCH, EMIT_LO, EMIT_HI. The word register `word` is 32 bit.
  - FETCH: if running && !fifo_empty, drive `fifo_rdreq`=1 combinationally this cycle and go to LATCH. Otherwise stay in FETCH.
  - LATCH: `word` <= `fifo_q`, then go to EMIT_LO. The capture happens even if `pause` rises in this cycle, because the read has already been issued.
  - EMIT_LO: on tick, `sample_out` <= `word[15:0]`, `sample_valid` <= 1, then go to EMIT_HI.
  - EMIT_HI: on tick, `sample_out` <= `word[31:16]`, `sample_valid` <= 1, then go to FETCH.
- Underflow: a tick that occurs in FETCH or LATCH increments `underflow_count` (saturating). In that case `sample_valid` stays 0 and `sample_out` holds its value.
- `stop` (any cycle): state becomes FETCH, `cnt` becomes 0, `sample_out` becomes 0, `sample_valid` becomes 0, and `fifo_rdreq` is 0. If `stop` is asserted in LATCH, that word is discarded. `underflow_count` is preserved.
- `pause`: state, `cnt`, `word` and `sample_out` all hold. `sample_valid` is 0 and `fifo_rdreq` is 0.
- `fifo_rdreq` is never asserted when `fifo_empty`=1. At most one read is outstanding.

## Timing
- Reset values: state FETCH, `cnt` 0, `word` 0, `sample_out` 0, `sample_valid` 0, `underflow_count` 0, `fifo_rdreq` 0.
- `sample_out`, `sample_valid` and `underflow_count` are registered. They update on the clock edge that ends the tick cycle and are visible the following cycle.
- `fifo_rdreq` is combinational from the state, `fifo_empty`, `stop` and `pause`.
- Refill path after the EMIT_HI tick at cycle t:
  - FETCH at t+1.
  - LATCH at t+2.
  - EMIT_LO at t+3.
  - The next tick comes no earlier than t+MIN_PERIOD = t+4, so no tick is lost when the FIFO is non-empty.
- Steady-state throughput: one sample every P clocks and one FIFO read every 2P clocks.
- After reset with a non-empty FIFO:
  - `fifo_rdreq` is asserted in the first cycle.
  - The first `sample_valid` is seen at cycle P (counting the first cycle after reset as 0).
- Changing `div_freq` takes effect from the next compare. No glitch pulse is produced other than the immediate-tick rule above.

## Test plan
- Continuous playback:
  - Stimulus: `div_freq`=10, FIFO preloaded with 0xBBBBAAAA and 0xDDDDCCCC.
  - Required: `sample_valid` pulses exactly 10 clocks apart, with `sample_out` = 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD in that order; exactly two `fifo_rdreq` pulses; `underflow_count` stays 0.
- Period floor:
  - Stimulus: `div_freq`=0, then 1, with a FIFO of 8 words.
  - Required: pulses are 4 clocks apart, all 16 samples are in order, and there are no underflows.
- Underflow:
  - Stimulus: `div_freq`=6, a single word in the FIFO, then run for 30 more clocks.
  - Required: two valid samples, then `underflow_count`=5, and `sample_out` holds the high half.
- Pause mid-word:
  - Stimulus: `div_freq`=8; assert `pause` for 20 clocks just after the low-half pulse.
  - Required: no pulses and no `fifo_rdreq` during the pause; the high half emits 8 − (cnt at pause) clocks after release.
- Stop in LATCH:
  - Stimulus: assert `stop` in the cycle after `fifo_rdreq`.
  - Required: `sample_out`=0; that word is never emitted; the next word fetched after `stop` drops plays normally; `underflow_count` is unchanged.
- Reset mid-operation and saturation:
  - Stimulus: synchronous `reset` while in EMIT_HI; separately, force 70000 empty ticks.
  - Required: all outputs return to their reset values the next cycle; `underflow_count` saturates at 0xFFFF.
